// File: rtl/align_shifter_if.sv
// align_shifter_if
//   Bundles the operand-side and result-side valid/ready channels of the
//   float-adder mantissa alignment stage.
//   Operand side : in_valid, in_ready, a, b, diff
//   Result side  : out_valid, out_ready, swap, big_sign, small_sign,
//                  exp_out, big_mant, small_mant
//   slave  modport : the alignment stage itself
//   master modport : whoever drives operands and consumes results
interface align_shifter_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) ();

  localparam int OP_W = 1 + EXP_W + MANT_W;
  localparam int BM_W = MANT_W + 1;
  localparam int SM_W = MANT_W + 4;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic [EXP_W:0]    diff;
  logic              out_valid;
  logic              out_ready;
  logic              swap;
  logic              big_sign;
  logic              small_sign;
  logic [EXP_W-1:0]  exp_out;
  logic [BM_W-1:0]   big_mant;
  logic [SM_W-1:0]   small_mant;

  modport slave (
    input  in_valid, a, b, diff, out_ready,
    output in_ready, out_valid, swap, big_sign, small_sign,
           exp_out, big_mant, small_mant
  );

  modport master (
    output in_valid, a, b, diff, out_ready,
    input  in_ready, out_valid, swap, big_sign, small_sign,
           exp_out, big_mant, small_mant
  );

endinterface

// File: rtl/align_shifter.sv
// align_shifter
//   Mantissa alignment stage of the float adder. Takes both IEEE-754 single
//   operands plus the {swap, |exp diff|} word from the exponent-difference
//   stage, keeps the larger-exponent operand as is, and right-shifts the
//   smaller mantissa one bit per cycle, collecting guard/round/sticky bits.
//   Ports:
//     clk  - clock
//     res  - synchronous active-high reset
//     bus  - align_shifter_if.slave (operand and result valid/ready channels)
//   Result small_mant layout: {hidden, fraction, guard, round, sticky}.
module align_shifter #(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 23,
  parameter int SAT_SHIFT = 26
) (
  input  logic            clk,
  input  logic            res,
  align_shifter_if.slave  bus
);

  localparam int BM_W  = MANT_W + 1;
  localparam int SM_W  = MANT_W + 4;
  localparam int CNT_W = $clog2(SAT_SHIFT + 1);

  localparam logic [EXP_W-1:0] SAT_EXP = EXP_W'(SAT_SHIFT);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(SAT_SHIFT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              swap_q,       swap_d;
  logic              big_sign_q,   big_sign_d;
  logic              small_sign_q, small_sign_d;
  logic [EXP_W-1:0]  exp_q,        exp_d;
  logic [BM_W-1:0]   big_mant_q,   big_mant_d;
  logic [SM_W-1:0]   small_mant_q, small_mant_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;

  logic              in_ready_o;
  logic              out_valid_o;
  logic              accept;

  // Operand field decode
  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp,  b_exp;
  logic [MANT_W-1:0] a_frac, b_frac;
  logic              a_hid,  b_hid;
  logic [CNT_W-1:0]  load_cnt;

  assign a_sign = bus.a[EXP_W+MANT_W];
  assign b_sign = bus.b[EXP_W+MANT_W];
  assign a_exp  = bus.a[EXP_W+MANT_W-1:MANT_W];
  assign b_exp  = bus.b[EXP_W+MANT_W-1:MANT_W];
  assign a_frac = bus.a[MANT_W-1:0];
  assign b_frac = bus.b[MANT_W-1:0];
  // Zero exponent field means denormal or zero: no implicit leading one
  assign a_hid  = |a_exp;
  assign b_hid  = |b_exp;

  // Shifts past SAT_SHIFT only push zeros into an already-final sticky bit,
  // so the count is clamped to keep the counter small and latency bounded
  assign load_cnt = (bus.diff[EXP_W-1:0] >= SAT_EXP) ? SAT_CNT
                                                       : bus.diff[CNT_W-1:0];

  assign accept = bus.in_valid && in_ready_o;

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (load_cnt == CNT_ZERO) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake flags depend on state only
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE:    in_ready_o  = 1'b1;
      DONE:    out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: load on accept, shift in SHIFT, hold otherwise
  always_comb begin
    swap_d       = swap_q;
    big_sign_d   = big_sign_q;
    small_sign_d = small_sign_q;
    exp_d        = exp_q;
    big_mant_d   = big_mant_q;
    small_mant_d = small_mant_q;
    cnt_d        = cnt_q;

    if (state_q == IDLE && accept) begin
      swap_d = bus.diff[EXP_W];
      cnt_d  = load_cnt;
      if (bus.diff[EXP_W]) begin
        big_sign_d   = b_sign;
        small_sign_d = a_sign;
        exp_d        = b_exp;
        big_mant_d   = {b_hid, b_frac};
        small_mant_d = {a_hid, a_frac, 3'b000};
      end else begin
        big_sign_d   = a_sign;
        small_sign_d = b_sign;
        exp_d        = a_exp;
        big_mant_d   = {a_hid, a_frac};
        small_mant_d = {b_hid, b_frac, 3'b000};
      end
    end else if (state_q == SHIFT) begin
      // The bit leaving the round position is folded into sticky so that
      // no shifted-out one is ever lost
      small_mant_d = {1'b0, small_mant_q[SM_W-1:2],
                      small_mant_q[1] | small_mant_q[0]};
      cnt_d        = cnt_q - CNT_ONE;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (res) begin
      swap_q       <= 1'b0;
      big_sign_q   <= 1'b0;
      small_sign_q <= 1'b0;
      exp_q        <= '0;
      big_mant_q   <= '0;
      small_mant_q <= '0;
      cnt_q        <= '0;
    end else begin
      swap_q       <= swap_d;
      big_sign_q   <= big_sign_d;
      small_sign_q <= small_sign_d;
      exp_q        <= exp_d;
      big_mant_q   <= big_mant_d;
      small_mant_q <= small_mant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_o;
  assign bus.out_valid  = out_valid_o;
  assign bus.swap       = swap_q;
  assign bus.big_sign   = big_sign_q;
  assign bus.small_sign = small_sign_q;
  assign bus.exp_out    = exp_q;
  assign bus.big_mant   = big_mant_q;
  assign bus.small_mant = small_mant_q;

endmodule

// File: tb/tb_align_shifter.sv
// tb_align_shifter
//   Directed-vector bench for align_shifter with hand-computed expectations.
module tb_align_shifter;

  logic clk;
  logic res;
  int   checks;
  int   errors;

  align_shifter_if bus ();

  align_shifter dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operand set for a single cycle; accepted at that edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [8:0] diff);
    checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.diff     = diff;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count cycles after the accepting edge until out_valid shows
  task automatic waitResult(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic checkResult(input string tag, input logic swap,
                             input logic bsign, input logic ssign,
                             input logic [7:0] exp, input logic [23:0] bm,
                             input logic [26:0] sm);
    checkOutput({tag, "_out_valid"},  32'(bus.out_valid),  32'd1);
    checkOutput({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    checkOutput({tag, "_swap"},       32'(bus.swap),       32'(swap));
    checkOutput({tag, "_big_sign"},   32'(bus.big_sign),   32'(bsign));
    checkOutput({tag, "_small_sign"}, 32'(bus.small_sign), 32'(ssign));
    checkOutput({tag, "_exp_out"},    32'(bus.exp_out),    32'(exp));
    checkOutput({tag, "_big_mant"},   32'(bus.big_mant),   32'(bm));
    checkOutput({tag, "_small_mant"}, 32'(bus.small_mant), 32'(sm));
  endtask

  // Consume the result and confirm the block returns to IDLE
  task automatic drainResult(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_drained_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_drained_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [8:0] diff,
                       input int lat, input logic swap, input logic bsign,
                       input logic ssign, input logic [7:0] exp,
                       input logic [23:0] bm, input logic [26:0] sm);
    applyStimulus(a, b, diff);
    waitResult(tag, lat);
    checkResult(tag, swap, bsign, ssign, exp, bm, sm);
    drainResult(tag);
  endtask

  initial begin
    int seen_valid;
    checks        = 0;
    errors        = 0;
    res           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.diff      = '0;
    repeat (2) @(posedge clk);
    #1;
    res = 1'b0;

    // Reset state
    checkOutput("rst_in_ready",   32'(bus.in_ready),   32'd1);
    checkOutput("rst_out_valid",  32'(bus.out_valid),  32'd0);
    checkOutput("rst_swap",       32'(bus.swap),       32'd0);
    checkOutput("rst_big_sign",   32'(bus.big_sign),   32'd0);
    checkOutput("rst_small_sign", 32'(bus.small_sign), 32'd0);
    checkOutput("rst_exp_out",    32'(bus.exp_out),    32'd0);
    checkOutput("rst_big_mant",   32'(bus.big_mant),   32'd0);
    checkOutput("rst_small_mant", 32'(bus.small_mant), 32'd0);

    // 1.0 + 0.5, one-bit shift, no swap
    runOp("t1", 32'h3F800000, 32'h3F000000, 9'h001, 1,
          1'b0, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h2000000);
    // Same pair swapped: b is the big operand
    runOp("t2", 32'h3F000000, 32'h3F800000, 9'h101, 1,
          1'b1, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h2000000);
    // 24-bit shift: hidden bit lands in guard, fraction LSB in sticky
    runOp("t3", 32'h4B800000, 32'h3F800001, 9'h018, 24,
          1'b0, 1'b0, 1'b0, 8'h97, 24'h800000, 27'h0000005);
    // Saturated count: 200 requested, 26 performed, all into sticky
    runOp("t4", 32'h7F000000, 32'h3F800000, 9'h0C8, 26,
          1'b0, 1'b0, 1'b0, 8'hFE, 24'h800000, 27'h0000001);
    // Denormal small operand (no hidden bit)
    runOp("t5", 32'h00800000, 32'h00000001, 9'h001, 1,
          1'b0, 1'b0, 1'b0, 8'h01, 24'h800000, 27'h0000004);
    // Negative big operand, signs routed through selection
    runOp("t6", 32'hC0000000, 32'h3F800000, 9'h001, 1,
          1'b0, 1'b1, 1'b0, 8'h80, 24'h800000, 27'h2000000);
    // Equal exponents: zero shift, straight to DONE
    runOp("t7", 32'h40400000, 32'hC0000000, 9'h000, 0,
          1'b0, 1'b0, 1'b1, 8'h80, 24'hC00000, 27'h4000000);
    // Swap with negative small operand
    runOp("t8", 32'hBF800000, 32'h40000000, 9'h101, 1,
          1'b1, 1'b0, 1'b1, 8'h80, 24'h800000, 27'h2000000);

    // Backpressure: result held for 5 cycles, competing input ignored
    applyStimulus(32'h3F800000, 32'h3F000000, 9'h001);
    waitResult("bp", 1);
    bus.in_valid = 1'b1;
    bus.a        = 32'h40000000;
    bus.b        = 32'h00000000;
    bus.diff     = 9'h000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkResult($sformatf("bp%0d", i), 1'b0, 1'b0, 1'b0, 8'h7F,
                  24'h800000, 27'h2000000);
    end
    bus.in_valid = 1'b0;
    drainResult("bp");

    // Reset during SHIFT discards the operation
    applyStimulus(32'h4B800000, 32'h3F800001, 9'h010);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_in_shift_ready", 32'(bus.in_ready), 32'd0);
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    checkOutput("mid_rst_out_valid",  32'(bus.out_valid),  32'd0);
    checkOutput("mid_rst_in_ready",   32'(bus.in_ready),   32'd1);
    checkOutput("mid_rst_small_mant", 32'(bus.small_mant), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1;
    end
    checkOutput("mid_rst_no_result", 32'(seen_valid), 32'd0);

    // Reset wins over a simultaneous in_valid
    res          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = 32'h3F800000;
    bus.b        = 32'h3F800000;
    bus.diff     = 9'h000;
    @(posedge clk);
    #1;
    res          = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("rstpri_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rstpri_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstpri_still_idle", 32'(bus.out_valid), 32'd0);

    // Normal operation after reset
    runOp("post", 32'h3F800000, 32'h3F000000, 9'h002, 2,
          1'b0, 1'b0, 1'b0, 8'h7F, 24'h800000, 27'h1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/align_shifter.md
Name: align_shifter

Overview:
- Mantissa alignment stage of the float adder, directly downstream of the exponent-difference stage.
- Consumes both IEEE-754 single operands plus the 9-bit {swap, |exp diff|} word that stage produces.
- Selects the larger-exponent operand and serially right-shifts the smaller mantissa by the difference, one bit per cycle, accumulating guard, round and sticky bits.
- Hands aligned mantissas to the mantissa add/subtract stage over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width. The hidden bit makes mantissas MANT_W+1 bits.
- SAT_SHIFT, 26, shift-count cap, equal to MANT_W+3. Any larger count gives an identical result.

Ports:
- clk  in  1  clock.
- res  in  1  synchronous reset, active-high.
- in_valid  in  1  a, b and diff are valid and mutually coherent.
- in_ready  out  1  block can accept an operand set.
- a  in  32  operand A, IEEE-754 single.
- b  in  32  operand B, IEEE-754 single.
- diff  in  9  from the exponent-difference stage. [8] = swap (1: exp_b > exp_a). [7:0] = |exp_a - exp_b|.
- out_valid  out  1  aligned result available.
- out_ready  in  1  downstream accepts the result.
- swap  out  1  registered diff[8].
- big_sign  out  1  sign of the selected larger operand.
- small_sign  out  1  sign of the other operand.
- exp_out  out  8  exponent of the larger operand.
- big_mant  out  24  {hidden, fraction} of the larger operand.
- small_mant  out  27  aligned smaller mantissa as {hidden, fraction, guard, round, sticky}.

Behaviour:
- Clock and reset: single clock, clk. res is synchronous and active-high.
- Reset: all outputs 0 except in_ready = 1. State = IDLE.
- Hidden bit: 1 if the exponent field is nonzero, else 0 (denormal or zero).
- Operand selection: swap = 0 (including equal exponents) makes a the big operand; swap = 1 makes b the big operand.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready, register the sign, exponent and mantissa of the big operand.
  - Load small_mant = {small hidden, small fraction, 3'b000}.
  - Load cnt = min(diff[7:0], SAT_SHIFT).
  - Next state is DONE if cnt == 0, else SHIFT.
- SHIFT:
  - Each cycle: small_mant <= {1'b0, small_mant[26:2], small_mant[1] | small_mant[0]}, and cnt <= cnt - 1.
  - Go to DONE when the cycle's pre-decrement cnt == 1.
  - in_ready = 0, out_valid = 0.
- DONE:
  - out_valid = 1. All outputs are held stable while out_ready = 0.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
  - No new input is accepted in the same cycle as an output handshake.
- Latency: accept at edge T, out_valid high from T+1+cnt. Throughput: one operation per 2+cnt cycles minimum.
- Saturation: diff[7:0] >= 26 shifts exactly 26 times. Every nonzero small-mantissa bit ends up in sticky.
- Trust rule: diff is used as given, with no cross-check against a and b. The upstream stage must present a, b and diff time-aligned.
- Reset mid-operation: res in any state discards the operation. The next cycle shows IDLE, out_valid = 0, in_ready = 1.
- Reset priority: res asserted together with in_valid means the input is not accepted.
- Special values: NaN and Inf are not special-cased here; they are passed through as ordinary fields.

Test Plan:
- a=3F800000, b=3F000000, diff=001, accept at T → at T+2: out_valid=1, swap=0, exp_out=7F, big_mant=800000, small_mant=2000000.
- a=3F000000, b=3F800000, diff=101 → at T+2: swap=1, exp_out=7F, big_mant=800000, small_mant=2000000.
- a=4B800000, b=3F800001, diff=018 → at T+25: exp_out=97, small_mant=0000005 (guard=1, sticky=1).
- diff=0C8 with small operand 3F800000 → exactly 26 shift cycles, out_valid at T+27, small_mant=0000001.
- Denormal small operand 00000001, a=00800000, diff=001 → small_mant=0000004 (hidden=0), out_valid at T+2.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0.
  - Assert res during SHIFT → next cycle out_valid=0, in_ready=1, and no result is emitted.
